// File: rtl/tug_ctrl_pkg.sv
// tug_ctrl_pkg -- shared definitions for the tug-of-war game controller.
//   state_t      : 2-bit FSM state encoding
//   POS_*        : rope position limits (0..6, centre 3)
//   WIN_TICKS    : length of a win display, in game ticks
//   BLINK_HALF   : ticks per half-period of the win blink
//   SCORE_MAX    : score saturation value
//   score_inc()  : saturating score increment
package tug_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_WIN_L = 2'd2,
    ST_WIN_R = 2'd3
  } state_t;

  localparam logic [2:0] POS_CENTRE  = 3'd3;
  localparam logic [2:0] POS_MAX     = 3'd6;
  // Last position from which a single move still stays in play.
  localparam logic [2:0] POS_LAST_L  = 3'd1;
  localparam logic [2:0] POS_LAST_R  = POS_MAX - 3'd1;

  localparam int         WIN_TICKS   = 16;
  localparam int         BLINK_HALF  = 4;
  localparam logic [3:0] TICK_LAST   = 4'(WIN_TICKS - 1);

  localparam logic [3:0] SCORE_MAX   = 4'd9;

  localparam int         NUM_PLAYERS = 2;
  localparam int         PLAYER_L    = 0;
  localparam int         PLAYER_R    = 1;

  function automatic logic [3:0] score_inc(input logic [3:0] score);
    return (score >= SCORE_MAX) ? SCORE_MAX : score + 4'd1;
  endfunction

endpackage

// File: rtl/tug_ctrl_btn_edge.sv
// btn_edge -- per-player button conditioning.
//   clk, rst : system clock, synchronous active-high reset
//   slowen   : one-clk game tick
//   pb       : raw asynchronous pushbutton, active-high
//   level    : synchronized button level
//   press    : one-clk pulse in a tick cycle where the level rose since the
//              previous tick (sampling only on ticks debounces the button)
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic slowen,
  input  logic pb,
  output logic level,
  output logic press
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      // Reset "previous" high so a button held through reset is not a press.
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= pb;
      sync2_reg <= sync1_reg;
      if (slowen) begin
        prev_reg <= sync2_reg;
      end
    end
  end

  assign level = sync2_reg;
  assign press = slowen & sync2_reg & ~prev_reg;

endmodule

// File: rtl/tug_ctrl.sv
// tug_ctrl -- two-player tug-of-war game controller.
//   clk, rst        : system clock, synchronous active-high reset
//   slowen          : one-clk game tick; all game decisions happen on it
//   pb_l, pb_r      : raw player pushbuttons, active-high
//   leds[6:0]       : rope position (one-hot) or blinking winner end
//   win_l, win_r    : high while the respective win display is shown
//   score_l/score_r : rounds won, saturating at 9
module tug_ctrl
  import tug_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       slowen,
  input  logic       pb_l,
  input  logic       pb_r,
  output logic [6:0] leds,
  output logic       win_l,
  output logic       win_r,
  output logic [3:0] score_l,
  output logic [3:0] score_r
);

  // Button conditioning, one instance per player
  logic [NUM_PLAYERS-1:0] pb_vec;
  logic [NUM_PLAYERS-1:0] level_vec;
  logic [NUM_PLAYERS-1:0] press_vec;

  assign pb_vec[PLAYER_L] = pb_l;
  assign pb_vec[PLAYER_R] = pb_r;

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_btn
      btn_edge u_btn_edge (
        .clk    (clk),
        .rst    (rst),
        .slowen (slowen),
        .pb     (pb_vec[gi]),
        .level  (level_vec[gi]),
        .press  (press_vec[gi])
      );
    end
  endgenerate

  logic level_l, level_r, press_l, press_r;
  assign level_l = level_vec[PLAYER_L];
  assign level_r = level_vec[PLAYER_R];
  assign press_l = press_vec[PLAYER_L];
  assign press_r = press_vec[PLAYER_R];

  // Game state
  state_t     state_reg,   state_next;
  logic [2:0] pos_reg,     pos_next;
  logic [3:0] score_l_reg, score_l_next;
  logic [3:0] score_r_reg, score_r_next;
  logic [3:0] tick_reg,    tick_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pos_reg     <= POS_CENTRE;
      score_l_reg <= 4'd0;
      score_r_reg <= 4'd0;
      tick_reg    <= 4'd0;
    end else begin
      state_reg   <= state_next;
      pos_reg     <= pos_next;
      score_l_reg <= score_l_next;
      score_r_reg <= score_r_next;
      tick_reg    <= tick_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pos_next     = pos_reg;
    score_l_next = score_l_reg;
    score_r_next = score_r_reg;
    tick_next    = tick_reg;

    if (slowen) begin
      case (state_reg)
        ST_IDLE: begin
          pos_next = POS_CENTRE;
          // Wait for both buttons released so a held button cannot score.
          if (!level_l && !level_r) begin
            state_next = ST_PLAY;
          end
        end

        ST_PLAY: begin
          // Simultaneous presses cancel out.
          if (press_l && !press_r) begin
            pos_next = pos_reg - 3'd1;
            if (pos_reg == POS_LAST_L) begin
              state_next   = ST_WIN_L;
              score_l_next = score_inc(score_l_reg);
              tick_next    = 4'd0;
            end
          end else if (press_r && !press_l) begin
            pos_next = pos_reg + 3'd1;
            if (pos_reg == POS_LAST_R) begin
              state_next   = ST_WIN_R;
              score_r_next = score_inc(score_r_reg);
              tick_next    = 4'd0;
            end
          end
        end

        ST_WIN_L, ST_WIN_R: begin
          if (tick_reg == TICK_LAST) begin
            state_next = ST_IDLE;
            pos_next   = POS_CENTRE;
            tick_next  = 4'd0;
          end else begin
            tick_next = tick_reg + 4'd1;
          end
        end

        default: begin
          state_next = ST_IDLE;
          pos_next   = POS_CENTRE;
        end
      endcase
    end
  end

  // Win blink: on for the first BLINK_HALF ticks, off for the next, repeating.
  logic blink_on;
  assign blink_on = ((int'(tick_reg) / BLINK_HALF) % 2) == 0;

  always_comb begin
    leds  = 7'b0;
    win_l = 1'b0;
    win_r = 1'b0;
    case (state_reg)
      ST_WIN_L: begin
        win_l   = 1'b1;
        leds[0] = blink_on;
      end
      ST_WIN_R: begin
        win_r         = 1'b1;
        leds[POS_MAX] = blink_on;
      end
      default: begin
        leds = 7'b1 << pos_reg;
      end
    endcase
  end

  assign score_l = score_l_reg;
  assign score_r = score_r_reg;

endmodule

// File: tb/tb_tug_ctrl.sv
// tb_tug_ctrl -- directed, table-driven bench for tug_ctrl, plus
// hand-written sequences for repeated wins, mid-win reset and short pulses.
module tb_tug_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       slowen = 1'b0;
  logic       pb_l = 1'b0;
  logic       pb_r = 1'b0;
  logic [6:0] leds;
  logic       win_l;
  logic       win_r;
  logic [3:0] score_l;
  logic [3:0] score_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tug_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .slowen  (slowen),
    .pb_l    (pb_l),
    .pb_r    (pb_r),
    .leds    (leds),
    .win_l   (win_l),
    .win_r   (win_r),
    .score_l (score_l),
    .score_r (score_r)
  );

  typedef struct {
    bit         do_rst;
    bit         pl;
    bit         pr;
    logic [6:0] leds;
    bit         wl;
    bit         wr;
    logic [3:0] sl;
    logic [3:0] sr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit l, input bit rr, input logic [6:0] ld,
                     input bit wl, input bit wr, input logic [3:0] sl, input logic [3:0] sr);
    vec_t v;
    v.do_rst = r; v.pl = l; v.pr = rr; v.leds = ld;
    v.wl = wl; v.wr = wr; v.sl = sl; v.sr = sr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One game tick: three quiet clocks (lets the synchronizers settle), then a
  // slowen clock. Returns at a falling edge, where outputs are sampled.
  task automatic tick();
    repeat (3) @(negedge clk);
    slowen = 1'b1;
    @(negedge clk);
    slowen = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {15'b0, leds, win_l, win_r, score_l, score_r};
  endfunction

  initial begin
    logic [31:0] exp;
    int          n;

    // rst, pb_l, pb_r, leds, win_l, win_r, score_l, score_r
    add(1, 0, 0, 7'h08, 0, 0, 0, 0);            // reset
    add(0, 0, 0, 7'h08, 0, 0, 0, 0);            // IDLE -> PLAY
    add(0, 0, 1, 7'h10, 0, 0, 0, 0);            // R press -> pos 4
    add(0, 0, 1, 7'h10, 0, 0, 0, 0);            // held, no move
    add(0, 0, 0, 7'h10, 0, 0, 0, 0);
    add(0, 0, 0, 7'h10, 0, 0, 0, 0);
    add(0, 0, 1, 7'h20, 0, 0, 0, 0);            // pos 5
    add(0, 0, 1, 7'h20, 0, 0, 0, 0);
    add(0, 0, 0, 7'h20, 0, 0, 0, 0);
    add(0, 0, 0, 7'h20, 0, 0, 0, 0);
    add(0, 0, 1, 7'h40, 0, 1, 0, 1);            // WIN_R tick 0
    add(0, 0, 1, 7'h40, 0, 1, 0, 1);            // tick 1, button ignored
    for (int i = 2; i < 4; i++)  add(0, 0, 0, 7'h40, 0, 1, 0, 1);
    for (int i = 4; i < 8; i++)  add(0, 0, 0, 7'h00, 0, 1, 0, 1);
    for (int i = 8; i < 12; i++) add(0, 0, 0, 7'h40, 0, 1, 0, 1);
    for (int i = 12; i < 16; i++) add(0, 0, 0, 7'h00, 0, 1, 0, 1);
    add(0, 0, 0, 7'h08, 0, 0, 0, 1);            // back to IDLE after 16 ticks
    add(0, 0, 0, 7'h08, 0, 0, 0, 1);            // IDLE -> PLAY
    add(0, 1, 1, 7'h08, 0, 0, 0, 1);            // simultaneous presses
    add(0, 0, 0, 7'h08, 0, 0, 0, 1);
    add(1, 1, 0, 7'h08, 0, 0, 0, 0);            // reset with pb_l held
    for (int i = 0; i < 5; i++) add(0, 1, 0, 7'h08, 0, 0, 0, 0);
    add(0, 0, 0, 7'h08, 0, 0, 0, 0);            // released -> PLAY, no move
    add(0, 1, 0, 7'h04, 0, 0, 0, 0);            // L press -> pos 2
    add(0, 0, 0, 7'h04, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      pb_l = vecs[i].pl;
      pb_r = vecs[i].pr;
      if (vecs[i].do_rst) rst = 1'b1;
      tick();
      rst = 1'b0;
      exp = {15'b0, vecs[i].leds, vecs[i].wl, vecs[i].wr, vecs[i].sl, vecs[i].sr};
      $display("vec %0d rst=%0b pb_l=%0b pb_r=%0b leds=%07b win_l=%0b win_r=%0b score_l=%0d score_r=%0d",
               i, vecs[i].do_rst, vecs[i].pl, vecs[i].pr, leds, win_l, win_r, score_l, score_r);
      check($sformatf("vec%0d", i), outs(), exp);
    end

    // Ten consecutive left wins: score saturates, each win lasts 16 ticks.
    pb_l = 1'b0; pb_r = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      pb_l = 1'b0; pb_r = 1'b0;
      tick();                                   // IDLE -> PLAY
      for (int p = 0; p < 3; p++) begin
        pb_l = 1'b1; tick(); pb_l = 1'b0;
        check($sformatf("lwin%0d_leds_p%0d", r, p), 32'(leds), 32'(7'b1 << (2 - p)));
        check($sformatf("lwin%0d_flag_p%0d", r, p), 32'(win_l), 32'(p == 2));
        if (p < 2) tick();
      end
      check($sformatf("lwin%0d_score_l", r), 32'(score_l), (r > 9) ? 32'd9 : 32'(r));
      n = 0;
      while (win_l && n < 20) begin
        pb_r = ((r % 2) == 1) && (n < 8);      // activity during WIN is ignored
        tick();
        n++;
        if (win_l) check($sformatf("lwin%0d_blink%0d", r, n), 32'(leds),
                         (((n / 4) % 2) == 0) ? 32'd1 : 32'd0);
      end
      pb_r = 1'b0;
      $display("round %0d: score_l=%0d score_r=%0d win ticks=%0d", r, score_l, score_r, n);
      check($sformatf("lwin%0d_len", r), 32'(n), 32'd16);
      check($sformatf("lwin%0d_idle_leds", r), 32'(leds), 32'h08);
      check($sformatf("lwin%0d_score_r", r), 32'(score_r), 32'd0);
    end

    // Right win, then reset during WIN_R tick 7 (together with slowen).
    pb_l = 1'b0; pb_r = 1'b0;
    tick();                                     // IDLE -> PLAY
    for (int p = 0; p < 3; p++) begin
      pb_r = 1'b1; tick(); pb_r = 1'b0;
      if (p < 2) tick();
    end
    check("rwin_flag", 32'(win_r), 32'd1);
    check("rwin_scores", {24'b0, score_l, score_r}, 32'h91);
    repeat (7) tick();
    check("rwin_tick7_leds", 32'(leds), 32'd0);
    check("rwin_tick7_flag", 32'(win_r), 32'd1);
    @(negedge clk);
    rst = 1'b1; slowen = 1'b1;
    @(negedge clk);
    rst = 1'b0; slowen = 1'b0;
    $display("mid-win reset: leds=%07b win_r=%0b score_l=%0d score_r=%0d", leds, win_r, score_l, score_r);
    check("mwrst_outs", outs(), {15'b0, 7'h08, 1'b0, 1'b0, 4'd0, 4'd0});

    // Short pulses between ticks never reach a slowen sample.
    tick();                                     // IDLE -> PLAY
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if ((k % 2) == 0) pb_r = 1'b1; else pb_l = 1'b1;
      @(negedge clk);
      pb_r = 1'b0; pb_l = 1'b0;
      tick();
      $display("short pulse %0d: leds=%07b", k, leds);
      check($sformatf("pulse%0d_leds", k), 32'(leds), 32'h08);
    end
    pb_r = 1'b1; tick(); pb_r = 1'b0;
    check("after_pulse_press", 32'(leds), 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tug_ctrl.md
TUG_CTRL -- requirements
Module: tug_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset sampled on the clk rising edge.
REQ-003 The block SHALL have port slowen, input, 1 bit: one-clk-wide game tick from the /1024 divider; all game decisions are taken only in cycles where slowen=1.
REQ-004 The block SHALL have ports pb_l and pb_r, input, 1 bit each: raw asynchronous player pushbuttons, active-high.
REQ-005 The block SHALL have port leds, output, 7 bits: rope position display, one-hot during play.
REQ-006 The block SHALL have ports win_l and win_r, output, 1 bit each: round-won level flags.
REQ-007 The block SHALL have ports score_l and score_r, output, 4 bits each: rounds won per player.

Function
REQ-008 Each button SHALL pass through a 2-flop synchronizer on clk; the synchronized level is called s_l or s_r.
REQ-009 On each slowen cycle the block SHALL register s_l and s_r as prev_l and prev_r; a press is defined as s_x=1 with prev_x=0 in the same slowen cycle (rising edge across two ticks, which gives debouncing).
REQ-010 Rope position pos SHALL be 3 bits in the range 0..6, with centre 3; leds SHALL equal 1<<pos during IDLE and PLAY.
REQ-011 The FSM SHALL have states IDLE, PLAY, WIN_L and WIN_R; reset enters IDLE.
REQ-012 In IDLE, pos SHALL be 3; on a slowen cycle with s_l=0 and s_r=0 the FSM SHALL go to PLAY, so buttons held through reset or a round end never score.
REQ-013 In PLAY, on a slowen cycle, a press_l alone SHALL decrement pos, a press_r alone SHALL increment pos, and simultaneous presses SHALL leave pos unchanged.
REQ-014 In PLAY, a decrement from pos=1 SHALL enter WIN_L, and an increment from pos=5 SHALL enter WIN_R, in the same edge as pos reaches 0 or 6.
REQ-015 On entry to a WIN state, the winner's score SHALL increment and saturate at 9; the other score SHALL be unchanged.
REQ-016 In WIN_L or WIN_R, the win flag SHALL be 1, and leds SHALL show only the winning end bit (bit 0 for L, bit 6 for R), blinking: on for 4 ticks, then off for 4 ticks, starting on.
REQ-017 A WIN state SHALL last exactly 16 slowen ticks, counted by a 4-bit tick counter cleared on entry, then go to IDLE with pos=3; button activity during WIN SHALL be ignored.
REQ-018 When slowen=0, no state, pos, score or prev register SHALL change; only the synchronizers advance.
REQ-019 Latency: a press decision taken in a slowen cycle SHALL be visible on leds and the flags at the next clk edge.

Reset
REQ-020 When rst=1, the block SHALL set state=IDLE, pos=3, leds=7'b0001000, win_l=win_r=0, score_l=score_r=0, tick counter=0, prev_l=prev_r=1 and synchronizers=0.
REQ-021 rst SHALL have priority over slowen and all other inputs.
REQ-022 rst asserted mid-round or mid-WIN SHALL abort the round with no score change beyond those already committed, and SHALL then clear the scores per REQ-020.

Structure
REQ-023 A shared package SHALL hold the state encoding (2-bit), POS_CENTRE=3, POS_MAX=6, WIN_TICKS=16, BLINK_HALF=4 and SCORE_MAX=9.
REQ-024 One sub-module, btn_edge, SHALL be instantiated once per player, containing the synchronizer plus the slowen-qualified edge detect of REQ-009.
REQ-025 The FSM, pos, scores and blink/tick counter SHALL reside in tug_ctrl.

Verification
REQ-026 Reset, then 1 slowen with buttons low -> PLAY, leds=0001000, scores=0.
REQ-027 3 separate pb_r presses, each held 2 ticks with 2-tick gaps -> pos 4,5, then WIN_R on the third press; win_r=1, score_r=1, leds=1000000 for 4 ticks then 0000000.
REQ-028 pb_l and pb_r pressed in the same tick -> pos stays 3, no flag.
REQ-029 pb_l held high through reset and for 5 ticks -> FSM stays IDLE; after release, next tick -> PLAY, with no move.
REQ-030 10 consecutive L wins -> score_l saturates at 9; each WIN_L lasts exactly 16 ticks before IDLE.
REQ-031 rst pulsed during WIN_R tick 7 -> next cycle IDLE, pos=3, win_r=0, scores=0; pb pulses between slowen ticks shorter than 1 tick -> no move.
